// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave that maps single-beat reads and writes onto a single-port synchronous memory.
// One transaction in flight at a time; writes win over reads; out-of-range addresses return DECERR.
module axi_lite_mem_slave #(
  parameter int ADDR_W   = 26,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [31:0]       s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_MEM  = 3'd1,
    WR_RESP = 3'd2,
    RD_MEM  = 3'd3,
    RD_WAIT = 3'd4,
    RD_RESP = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] LAT_LOAD    = 2'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic        aw_held_q, w_held_q;
  logic [29:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wr_oor_q, rd_oor_q;
  logic [1:0]  lat_cnt_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        aw_avail, w_avail;
  logic [29:0] cur_aw_word, ar_word;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        wr_oor, rd_oor;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign dbg_state        = state_q;

  // Every channel uses valid/ready: a beat transfers on a rising clk edge where both are
  // high; the source keeps valid and its payload steady until that edge.
  assign s_axi_awready = (state_q == IDLE) && !aw_held_q;
  assign s_axi_wready  = (state_q == IDLE) && !w_held_q;
  assign s_axi_arready = (state_q == IDLE) && !aw_held_q && !w_held_q &&
                         !s_axi_awvalid && !s_axi_wvalid;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  assign aw_avail    = aw_held_q || aw_hs;
  assign w_avail     = w_held_q || w_hs;
  assign cur_aw_word = aw_held_q ? awaddr_q : s_axi_awaddr[31:2];
  assign cur_wdata   = w_held_q ? wdata_q : s_axi_wdata;
  assign cur_wstrb   = w_held_q ? wstrb_q : s_axi_wstrb;
  assign ar_word     = s_axi_araddr[31:2];
  assign wr_oor      = |cur_aw_word[29:ADDR_W];
  assign rd_oor      = |ar_word[29:ADDR_W];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (aw_avail && w_avail) state_d = WR_MEM;
        else if (ar_hs)          state_d = RD_MEM;
      end
      WR_MEM:  state_d = WR_RESP;
      WR_RESP: if (s_axi_bready) state_d = IDLE;
      RD_MEM:  state_d = RD_WAIT;
      RD_WAIT: if (lat_cnt_q == 2'd0) state_d = RD_RESP;
      RD_RESP: if (s_axi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wr_oor_q     <= 1'b0;
      rd_oor_q     <= 1'b0;
      lat_cnt_q    <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rdata  <= '0;
      mem_en       <= 1'b0;
      mem_we       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state_q <= state_d;
      mem_en  <= 1'b0;
      mem_we  <= '0;

      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axi_awaddr[31:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axi_wdata;
        wstrb_q  <= s_axi_wstrb;
      end

      case (state_q)
        IDLE: begin
          // Memory strobe is registered here so it lands exactly in WR_MEM / RD_MEM.
          if (aw_avail && w_avail) begin
            wr_oor_q  <= wr_oor;
            mem_en    <= !wr_oor && (cur_wstrb != 4'b0000);
            mem_we    <= wr_oor ? 4'b0000 : cur_wstrb;
            mem_addr  <= cur_aw_word[ADDR_W-1:0];
            mem_wdata <= cur_wdata;
          end else if (ar_hs) begin
            rd_oor_q <= rd_oor;
            mem_en   <= !rd_oor;
            mem_addr <= ar_word[ADDR_W-1:0];
          end
        end
        WR_MEM: begin
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= wr_oor_q ? RESP_DECERR : RESP_OKAY;
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
          end
        end
        RD_MEM: lat_cnt_q <= LAT_LOAD;
        RD_WAIT: begin
          // Last wait cycle is the one where mem_rdata is valid.
          if (lat_cnt_q == 2'd0) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_oor_q ? 32'h0 : mem_rdata;
            s_axi_rresp  <= rd_oor_q ? RESP_DECERR : RESP_OKAY;
          end else begin
            lat_cnt_q <= lat_cnt_q - 2'd1;
          end
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Bench for axi_lite_mem_slave: READ_LAT=1 instance with byte-strobed memory model, plus a
// READ_LAT=3 instance for latency and mid-read reset.
`timescale 1ns/1ps
module tb_axi_lite_mem_slave;
  localparam int ADDR_W = 26;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, rstn2;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 1 (READ_LAT=1) ----------------
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [3:0]  s_axi_wstrb, mem_we;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready, mem_en;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  axi_lite_mem_slave #(.ADDR_W(ADDR_W), .READ_LAT(1)) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- DUT 2 (READ_LAT=3, reads only) ----------------
  logic [31:0] zero32 = '0;
  logic [3:0]  zero4 = '0;
  logic        zero1 = 1'b0;
  logic [31:0] araddr2, rdata2, mem_wdata2, mem_rdata2;
  logic        arvalid2, arready2, rvalid2, rready2, bvalid2, awready2, wready2, mem_en2;
  logic [1:0]  rresp2, bresp2;
  logic [3:0]  mem_we2;
  logic [ADDR_W-1:0] mem_addr2;
  logic [2:0]  dbg_state2;

  axi_lite_mem_slave #(.ADDR_W(ADDR_W), .READ_LAT(3)) dut2 (
    .clk(clk), .rstn(rstn2),
    .s_axi_awaddr(zero32), .s_axi_awvalid(zero1), .s_axi_awready(awready2),
    .s_axi_wdata(zero32), .s_axi_wstrb(zero4), .s_axi_wvalid(zero1),
    .s_axi_wready(wready2), .s_axi_bresp(bresp2), .s_axi_bvalid(bvalid2),
    .s_axi_bready(zero1), .s_axi_araddr(araddr2), .s_axi_arvalid(arvalid2),
    .s_axi_arready(arready2), .s_axi_rdata(rdata2), .s_axi_rresp(rresp2),
    .s_axi_rvalid(rvalid2), .s_axi_rready(rready2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .dbg_state(dbg_state2)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [ADDR_W-1:0]];
  logic [31:0] p0, p1, p2;

  always @(posedge clk) begin
    logic [31:0] tmp;
    mem_rdata <= 32'hDEAD_BEEF;
    if (mem_en) begin
      tmp = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      if (mem_we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) tmp[8*b +: 8] = mem_wdata[8*b +: 8];
        mem[mem_addr] = tmp;
      end else begin
        mem_rdata <= tmp;
      end
    end
  end

  always @(posedge clk) begin
    p0 <= (mem_en2 && mem_we2 == 4'b0000) ?
          (mem.exists(mem_addr2) ? mem[mem_addr2] : 32'h0) : 32'hDEAD_BEEF;
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata2 = p2;

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];   // {resp, rdata} per B/R response
  logic [61:0] mem_q[$];   // {we, addr, wdata} per memory access (wdata 0 for reads)
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && mem_en) begin
      if (mem_q.size() == 0) check("mem_unexpected_en", 64'(mem_en), 64'd0);
      else check("mem_access",
                 64'({mem_we, mem_addr, (mem_we != 4'b0000) ? mem_wdata : 32'h0}),
                 64'(mem_q.pop_front()));
    end
  end

  // ---------------- driver tasks (DUT 1) ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, output int hs_cyc);
    logic aw_done = 1'b0, w_done = 1'b0, aw_now, w_now;
    logic in_range = (addr[31:ADDR_W+2] == '0);
    int k = 0;
    hs_cyc = -100;
    exp_q.push_back({in_range ? 2'b00 : 2'b11, 32'h0});
    if (in_range && strb != 4'b0000) mem_q.push_back({strb, addr[ADDR_W+1:2], data});
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    while (!(aw_done && w_done) && k < 40) begin
      if (k == w_lead) begin s_axi_awaddr = addr; s_axi_awvalid = 1'b1; end
      @(negedge clk);
      aw_now = s_axi_awvalid && s_axi_awready;
      w_now  = s_axi_wvalid && s_axi_wready;
      check("arready_blocked", 64'(s_axi_arready), 64'd0);
      if (w_done && !aw_done) check("wready_low_while_held", 64'(s_axi_wready), 64'd0);
      if (aw_now) aw_done = 1'b1;
      if (w_now)  w_done = 1'b1;
      if (aw_done && w_done) hs_cyc = cyc;
      @(posedge clk); #1;
      if (aw_now) s_axi_awvalid = 1'b0;
      if (w_now)  s_axi_wvalid = 1'b0;
      k++;
    end
    if (!(aw_done && w_done)) check("wr_handshake", 64'({aw_done, w_done}), 64'd3);
    @(negedge clk);
    check("wr_mem_en", 64'(mem_en), 64'(in_range && strb != 4'b0000));
  endtask

  task automatic wait_b(input int hs_cyc, input int hold, output int b_hs_cyc);
    int guard = 0;
    logic [33:0] e;
    e = (exp_q.size() > 0) ? exp_q[0] : 34'h3_FFFF_FFFF;
    do begin @(negedge clk); guard++; end while (!s_axi_bvalid && guard < 20);
    check("b_latency", 64'(cyc - hs_cyc), 64'd2);
    for (int i = 0; i < hold; i++) begin
      check("b_hold", 64'({s_axi_bvalid, s_axi_bresp, mem_en, s_axi_awready,
                           s_axi_wready, s_axi_arready}), 64'({1'b1, e[33:32], 4'b0000}));
      @(negedge clk);
    end
    check("bvalid", 64'(s_axi_bvalid), 64'd1);
    check("bresp", 64'(s_axi_bresp), 64'(e[33:32]));
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    s_axi_bready = 1'b1;
    b_hs_cyc = cyc;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] data,
                          input int want_hs, output int hs_cyc);
    int guard = 0;
    logic [33:0] e;
    logic in_range = (addr[31:ADDR_W+2] == '0);
    exp_q.push_back({in_range ? 2'b00 : 2'b11, in_range ? data : 32'h0});
    if (in_range) mem_q.push_back({4'b0000, addr[ADDR_W+1:2], 32'h0});
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    do begin @(negedge clk); guard++; end while (!s_axi_arready && guard < 20);
    hs_cyc = cyc;
    if (want_hs >= 0) check("ar_accept_cycle", 64'(hs_cyc), 64'(want_hs));
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!s_axi_rvalid && guard < 20);
    check("r_latency", 64'(cyc - hs_cyc), 64'd3);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    check("rresp", 64'(s_axi_rresp), 64'(e[33:32]));
    check("rdata", 64'(s_axi_rdata), 64'(e[31:0]));
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic axi_read2(input logic [31:0] addr, input logic [31:0] data);
    int guard = 0, hs;
    araddr2 = addr; arvalid2 = 1'b1;
    do begin @(negedge clk); guard++; end while (!arready2 && guard < 20);
    hs = cyc;
    @(posedge clk); #1;
    arvalid2 = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rvalid2 && guard < 20);
    check("r2_latency", 64'(cyc - hs), 64'd5);
    check("r2_rdata_rresp", 64'({rresp2, rdata2}), 64'({2'b00, data}));
    rready2 = 1'b1;
    @(posedge clk); #1;
    rready2 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs, bhs, lead, hs2;
    logic [31:0] a, d;
    logic saw_rvalid;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; araddr2 = '0; arvalid2 = 1'b0; rready2 = 1'b0;
    rstn = 1'b0; rstn2 = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, mem_en,
                                mem_we, dbg_state}), 64'd0);
    check("reset_data", 64'(s_axi_rdata | mem_wdata | 32'(mem_addr)), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1; rstn2 = 1'b1;
    @(negedge clk);
    check("idle_readys", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd7);
    @(posedge clk); #1;

    // Same-cycle AW/W, then read back.
    axi_write(32'h0100_0000, 32'h0000_00AA, 4'hF, 0, hs);
    wait_b(hs, 0, bhs);
    axi_read(32'h0100_0000, 32'h0000_00AA, -1, hs);

    // W three cycles ahead of AW.
    axi_write(32'h0100_0010, 32'h0000_BBBB, 4'hF, 3, hs);
    wait_b(hs, 0, bhs);

    // AR contends with a write and is accepted the cycle after the B handshake.
    s_axi_araddr = 32'h0100_0010; s_axi_arvalid = 1'b1;
    axi_write(32'h0100_0020, 32'h0000_C0DE, 4'hF, 0, hs);
    wait_b(hs, 5, bhs);
    axi_read(32'h0100_0010, 32'h0000_BBBB, bhs + 1, hs);

    // Out-of-range write and read.
    axi_write(32'h1000_0000, 32'h0000_0055, 4'hF, 0, hs);
    wait_b(hs, 0, bhs);
    axi_read(32'hF000_0000, 32'h0, -1, hs);

    // Partial strobe, then zero strobe (no access, OKAY response).
    axi_write(32'h0F00_0000, 32'h1234_5678, 4'b0011, 0, hs);
    wait_b(hs, 0, bhs);
    axi_write(32'h0F00_0000, 32'hFFFF_FFFF, 4'b0000, 1, hs);
    wait_b(hs, 0, bhs);
    axi_read(32'h0F00_0000, 32'h0000_5678, -1, hs);

    // Random full-word write/read-back pairs.
    for (int i = 0; i < 4; i++) begin
      a = 32'h0200_0000 + ($urandom_range(0, 255) << 2);
      d = $urandom;
      lead = $urandom_range(0, 2);
      axi_write(a, d, 4'hF, lead, hs);
      wait_b(hs, $urandom_range(0, 2), bhs);
      axi_read(a, d, -1, hs);
    end

    // READ_LAT=3 instance: normal read, reset during RD_WAIT, then normal read again.
    axi_read2(32'h0100_0000, 32'h0000_00AA);
    araddr2 = 32'h0100_0010; arvalid2 = 1'b1;
    hs2 = 0;
    do begin @(negedge clk); hs2++; end while (!arready2 && hs2 < 20);
    @(posedge clk); #1;
    arvalid2 = 1'b0;
    @(posedge clk); #1;
    rstn2 = 1'b0;
    @(negedge clk);
    check("r2_in_rd_wait", 64'(dbg_state2), 64'd4);
    @(posedge clk); #1;
    @(negedge clk);
    check("r2_reset_outputs", 64'({rvalid2, rresp2, rdata2, bvalid2, bresp2, mem_en2, mem_we2,
                                   mem_addr2, dbg_state2}), 64'd0);
    @(posedge clk); #1;
    rstn2 = 1'b1;
    saw_rvalid = 1'b0;
    repeat (10) begin @(negedge clk); if (rvalid2) saw_rvalid = 1'b1; end
    check("r2_no_rvalid_after_reset", 64'(saw_rvalid), 64'd0);
    @(posedge clk); #1;
    axi_read2(32'h0100_0010, 32'h0000_BBBB);

    repeat (3) @(posedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
